// File: rtl/sccb_reg_sequencer.sv
// rtl/sccb_reg_sequencer.sv - register-table SCCB write sequencer with delay entries, retries and watchdog
module sccb_reg_sequencer #(
  parameter int         DEPTH          = 75,
  parameter int         ADDR_W         = 7,
  parameter logic [7:0] SLAVE_ADDR     = 8'h42,
  parameter logic [7:0] DELAY_REG      = 8'hFF,
  parameter int         TICKS_PER_UNIT = 100,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT        = 4095
) (
  input  logic              clock_100khz,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              i2c_go,
  output logic [23:0]       i2c_data,
  input  logic              i2c_end,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_index,
  output logic [3:0]        retry_cnt
);

  localparam int                WD_W        = $clog2(TIMEOUT + 1);
  localparam logic [23:0]       TICKS       = 24'(TICKS_PER_UNIT);
  localparam logic [ADDR_W-1:0] LAST        = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT_END, CHECK, DELAY, NEXT, DONE, ERROR
  } state_t;

  state_t            state, next_state;
  logic [23:0]       delay_cnt;
  logic [23:0]       delay_load;
  logic [WD_W-1:0]   wdog;
  logic              fail;
  logic              is_delay;
  logic              can_retry;
  logic              wd_expired;

  assign delay_load = {16'd0, tbl_data[7:0]} * TICKS;
  assign is_delay   = (tbl_data[15:8] == DELAY_REG);
  assign can_retry  = (retry_cnt < RETRY_LIMIT);
  assign wd_expired = (wdog == WD_LAST);

  always_ff @(posedge clock_100khz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start) next_state = FETCH;
        FETCH:    next_state = LOAD;
        LOAD:     next_state = is_delay ? DELAY : ISSUE;
        // Wait for the engine to drop a previous END before requesting again.
        ISSUE:    if (!i2c_end) next_state = WAIT_END;
        WAIT_END: if (i2c_end || wd_expired) next_state = CHECK;
        CHECK: begin
          if (!fail)          next_state = NEXT;
          else if (can_retry) next_state = ISSUE;
          else                next_state = ERROR;
        end
        DELAY:    if (delay_cnt <= 24'd1) next_state = NEXT;
        NEXT:     next_state = (tbl_addr == LAST) ? DONE : FETCH;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Status and GO follow the registered next state so they change with it.
  always_ff @(posedge clock_100khz or negedge reset) begin
    if (!reset) begin
      tbl_addr  <= '0;
      i2c_go    <= 1'b0;
      i2c_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      retry_cnt <= '0;
      delay_cnt <= '0;
      wdog      <= '0;
      fail      <= 1'b0;
    end else begin
      i2c_go <= (next_state == WAIT_END);
      busy   <= !(next_state inside {IDLE, DONE, ERROR});
      done   <= (next_state == DONE);
      error  <= (next_state == ERROR);
      if (!abort) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (start) begin
              tbl_addr  <= '0;
              retry_cnt <= '0;
              err_index <= '0;
            end
          end
          LOAD: begin
            if (is_delay) delay_cnt <= delay_load;
            else          i2c_data  <= {SLAVE_ADDR, tbl_data};
          end
          ISSUE: wdog <= '0;
          WAIT_END: begin
            if (i2c_end)         fail <= i2c_nack;
            else if (wd_expired) fail <= 1'b1;
            else                 wdog <= wdog + 1'b1;
          end
          CHECK: begin
            if (fail && can_retry) retry_cnt <= retry_cnt + 4'd1;
            else if (fail)         err_index <= tbl_addr;
          end
          DELAY: if (delay_cnt > 24'd1) delay_cnt <= delay_cnt - 24'd1;
          NEXT: begin
            if (tbl_addr != LAST) begin
              tbl_addr  <= tbl_addr + 1'b1;
              retry_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// tb/tb_sccb_reg_sequencer.sv - randomized bench for sccb_reg_sequencer against a table-level model
module tb_sccb_reg_sequencer;

  localparam int         DEPTH     = 4;
  localparam int         ADDR_W    = 2;
  localparam int         TPU       = 100;
  localparam int         MAX_RETRY = 3;
  localparam int         TIMEOUT   = 50;
  localparam logic [7:0] SLAVE     = 8'h42;
  localparam logic [7:0] DREG      = 8'hFF;

  logic              clock_100khz = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              i2c_end = 1'b0;
  logic              i2c_nack = 1'b0;
  logic [ADDR_W-1:0] tbl_addr;
  logic [15:0]       tbl_data;
  logic              i2c_go;
  logic [23:0]       i2c_data;
  logic              busy, done, error;
  logic [ADDR_W-1:0] err_index;
  logic [3:0]        retry_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [DEPTH];
  int          beh_e[$];
  bit          beh_n[$];
  logic [23:0] exp_data[$];
  int          exp_retry[$], exp_rise[$], exp_fall[$];
  int          exp_cycles, exp_eidx, exp_final_retry;
  bit          exp_err;

  logic [23:0] obs_data[$];
  int          obs_retry[$], obs_rise[$], obs_fall[$];
  int          glitch = 0;
  int          cyc = 0;
  int          base = 0;

  sccb_reg_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SLAVE_ADDR(SLAVE), .DELAY_REG(DREG),
    .TICKS_PER_UNIT(TPU), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_100khz(clock_100khz), .reset(reset), .start(start), .abort(abort),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .i2c_go(i2c_go), .i2c_data(i2c_data),
    .i2c_end(i2c_end), .i2c_nack(i2c_nack), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .retry_cnt(retry_cnt)
  );

  always #5 clock_100khz = ~clock_100khz;

  always @(posedge clock_100khz) tbl_data <= rom[tbl_addr];
  always @(posedge clock_100khz) cyc <= cyc + 1;

  // Engine: END appears for one sample after E clocks of GO; E > TIMEOUT means never.
  int   cur_e = 20;
  bit   cur_n = 1'b0;
  int   go_cnt = 0;
  logic go_prev = 1'b0;
  always @(negedge clock_100khz) begin
    if (i2c_go && !go_prev) begin
      if (beh_e.size() > 0) begin
        cur_e = beh_e.pop_front();
        cur_n = beh_n.pop_front();
      end else begin
        cur_e = 20;
        cur_n = 1'b0;
      end
      go_cnt = 1;
    end else if (i2c_go) begin
      go_cnt++;
    end
    go_prev = i2c_go;
    if (i2c_go && go_cnt == cur_e) begin
      i2c_end  = 1'b1;
      i2c_nack = cur_n;
    end else begin
      i2c_end  = 1'b0;
      i2c_nack = 1'($urandom_range(0, 1));
    end
  end

  logic        mon_prev = 1'b0;
  logic [23:0] held = '0;
  always @(negedge clock_100khz) begin
    if (i2c_go && !mon_prev) begin
      obs_data.push_back(i2c_data);
      obs_retry.push_back(int'(retry_cnt));
      obs_rise.push_back(cyc);
      held = i2c_data;
    end else if (i2c_go && i2c_data !== held) begin
      glitch++;
    end
    if (!i2c_go && mon_prev) obs_fall.push_back(cyc);
    mon_prev = i2c_go;
  end

  // Expected run, in clocks after the start edge, built entry by entry from the table rules.
  task automatic build_model(input int mode);
    int t, issue_t, e, w;
    bit n, fail;
    beh_e.delete(); beh_n.delete();
    exp_data.delete(); exp_retry.delete(); exp_rise.delete(); exp_fall.delete();
    t = 0; exp_err = 0; exp_eidx = 0; exp_final_retry = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_err) break;
      exp_final_retry = 0;
      if (rom[i][15:8] == DREG) begin
        w = rom[i][7:0] * TPU;
        if (w == 0) w = 1;
        t += 3 + w;
      end else begin
        issue_t = t + 2;
        for (int a = 0; a <= MAX_RETRY; a++) begin
          case (mode)
            1: begin
              case ($urandom_range(0, 9))
                0:       e = 1000;
                1:       e = TIMEOUT;
                default: e = $urandom_range(1, 30);
              endcase
              n = ($urandom_range(0, 3) == 0);
            end
            2:       begin e = 20;   n = (i == 1 && a < 2); end
            3:       begin e = 20;   n = (i == 2); end
            4:       begin e = 1000; n = 1'b0; end
            default: begin e = 20;   n = 1'b0; end
          endcase
          w    = (e > TIMEOUT) ? TIMEOUT : e;
          fail = n || (e > TIMEOUT);
          beh_e.push_back(e);
          beh_n.push_back(n);
          exp_data.push_back({SLAVE, rom[i]});
          exp_retry.push_back(a);
          exp_rise.push_back(issue_t + 1);
          exp_fall.push_back(issue_t + 1 + w);
          exp_final_retry = a;
          issue_t += 2 + w;
          if (!fail) break;
          if (a == MAX_RETRY) begin
            exp_err  = 1'b1;
            exp_eidx = i;
          end
        end
        t = exp_err ? issue_t : issue_t + 1;
      end
    end
    exp_cycles = t;
  endtask

  task automatic test_table(input string name, input int mode);
    int   cycles, fall_i;
    logic s_busy, s_done, s_error;
    logic [ADDR_W-1:0] s_addr, s_eidx;
    build_model(mode);
    obs_data.delete(); obs_retry.delete(); obs_rise.delete(); obs_fall.delete();
    glitch = 0;
    @(negedge clock_100khz); start = 1'b1;
    @(posedge clock_100khz); #1; start = 1'b0; base = cyc;
    s_busy = busy; s_done = done; s_error = error; s_addr = tbl_addr; s_eidx = err_index;
    cycles = 0;
    while (!(done || error) && cycles < 5000) begin
      @(posedge clock_100khz); #1; cycles++;
    end
    checks++;
    if ({s_busy, s_done, s_error, s_addr, s_eidx} !== {3'b100, {2*ADDR_W{1'b0}}}) begin
      errors++;
      $display("FAIL %s start_state: busy=%b done=%b error=%b addr=%0d eidx=%0d required 1 0 0 0 0",
               name, s_busy, s_done, s_error, s_addr, s_eidx);
    end
    checks++;
    if (cycles != exp_cycles) begin
      errors++;
      $display("FAIL %s run_length: got %0d clocks, required %0d", name, cycles, exp_cycles);
    end
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s go_pulses: got %0d, required %0d", name, obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      fall_i = (i < obs_fall.size()) ? obs_fall[i] - base : -1;
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_retry[i] != exp_retry[i] ||
          obs_rise[i] - base != exp_rise[i] || fall_i != exp_fall[i]) begin
        errors++;
        $display("FAIL %s pulse%0d: data=%h retry=%0d rise=%0d fall=%0d required data=%h retry=%0d rise=%0d fall=%0d",
                 name, i, obs_data[i], obs_retry[i], obs_rise[i] - base, fall_i,
                 exp_data[i], exp_retry[i], exp_rise[i], exp_fall[i]);
      end
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL %s data_stable: %0d changes while GO high, required 0", name, glitch);
    end
    checks++;
    if ({done, error, busy} !== {!exp_err, exp_err, 1'b0} || retry_cnt !== 4'(exp_final_retry)) begin
      errors++;
      $display("FAIL %s end_state: done=%b error=%b busy=%b retry=%0d required %b %b 0 retry=%0d",
               name, done, error, busy, retry_cnt, !exp_err, exp_err, exp_final_retry);
    end
    if (exp_err) begin
      checks++;
      if (err_index !== ADDR_W'(exp_eidx)) begin
        errors++;
        $display("FAIL %s err_index: got %0d, required %0d", name, err_index, exp_eidx);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock_100khz);
    checks++;
    if ({tbl_addr, i2c_go, i2c_data, busy, done, error, err_index, retry_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: addr=%0d go=%b data=%h busy=%b done=%b error=%b eidx=%0d retry=%0d required all 0",
               tbl_addr, i2c_go, i2c_data, busy, done, error, err_index, retry_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_write_table();
    rom[0] = 16'h1280; rom[1] = 16'h1180; rom[2] = 16'h0C00; rom[3] = 16'h3E01;
    test_table("write_table", 0);
  endtask

  task automatic test_delay();
    rom[0] = 16'hFF02; rom[1] = 16'h1214; rom[2] = 16'hFF00; rom[3] = 16'hFF01;
    test_table("delay", 0);
  endtask

  task automatic test_retry();
    rom[0] = 16'h1280; rom[1] = 16'h1180; rom[2] = 16'h0C00; rom[3] = 16'h3E01;
    test_table("retry", 2);
  endtask

  task automatic test_error_restart();
    for (int i = 0; i < DEPTH; i++) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
    test_table("error", 3);
    test_table("rerun_after_error", 0);
  endtask

  task automatic test_timeout();
    test_table("timeout", 4);
  endtask

  task automatic test_random_tables();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 4) == 0) rom[i] = {DREG, 8'($urandom_range(0, 2))};
        else                           rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
      end
      test_table($sformatf("random%0d", k), 1);
    end
  endtask

  task automatic test_abort();
    int n;
    rom[0] = 16'h1280; rom[1] = 16'h1180; rom[2] = 16'h0C00; rom[3] = 16'h3E01;
    build_model(0);
    @(negedge clock_100khz); start = 1'b1;
    @(posedge clock_100khz); #1; start = 1'b0;
    n = 0;
    while (!i2c_go && n < 100) begin
      @(posedge clock_100khz); #1; n++;
    end
    checks++;
    if (i2c_go !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: go=%b after %0d clocks, required 1", i2c_go, n);
    end
    repeat (3) @(posedge clock_100khz);
    @(negedge clock_100khz); abort = 1'b1;
    @(posedge clock_100khz); #1;
    checks++;
    if ({i2c_go, busy, done, error} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_wait_end: go=%b busy=%b done=%b error=%b required 0 0 0 0", i2c_go, busy, done, error);
    end
    @(negedge clock_100khz); start = 1'b1;
    @(posedge clock_100khz); #1;
    checks++;
    if ({i2c_go, busy, done, error} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_over_start: go=%b busy=%b done=%b error=%b required 0 0 0 0", i2c_go, busy, done, error);
    end
    @(negedge clock_100khz); start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    build_model(0);
    @(negedge clock_100khz); start = 1'b1;
    @(posedge clock_100khz); #1; start = 1'b0;
    n = 0;
    while (!(i2c_go && tbl_addr == 1) && n < 200) begin
      @(posedge clock_100khz); #1; n++;
    end
    checks++;
    if (!(i2c_go === 1'b1 && tbl_addr == 1)) begin
      errors++;
      $display("FAIL reset_mid_setup: go=%b addr=%0d after %0d clocks, required 1 1", i2c_go, tbl_addr, n);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tbl_addr, i2c_go, i2c_data, busy, done, error, err_index, retry_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: addr=%0d go=%b data=%h busy=%b done=%b error=%b eidx=%0d retry=%0d required all 0",
               tbl_addr, i2c_go, i2c_data, busy, done, error, err_index, retry_cnt);
    end
    @(negedge clock_100khz); reset = 1'b1;
    repeat (2) @(negedge clock_100khz);
  endtask

  initial begin
    test_reset();
    test_write_table();
    test_delay();
    test_retry();
    test_error_restart();
    test_timeout();
    test_random_tables();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
